// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and the
// default operand width.
package vlsi_pkg;

    localparam int VLSI_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : vlsi_pkg

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the serial subtractor.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. The producer holds its payload stable while
// valid is high and ready is low; ready may depend on the consumer's state but
// never on valid of the same channel.
//
// 'state' is a debug view of the FSM for checkers and probes.
interface serial_subtractor_if
    import vlsi_pkg::*;
#(
    parameter int WIDTH = VLSI_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             busy;
    state_t           state;

    // Engine side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, busy, state
    );

    // Producer/consumer side.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, busy, state
    );

endinterface : serial_subtractor_if

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the bit
// position has to borrow from the next one up.
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference and borrow-out of a single bit position.
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule : full_subtractor_bit

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor. Operands are accepted in IDLE, processed
// LSB-first one bit per clock in RUN, and the difference plus final borrow
// are presented in DONE until the consumer takes them.
//
// RUN spends WIDTH shift cycles followed by one commit cycle in which the
// finished shift register is copied into the result registers. That keeps
// the visible diff/borrow untouched while bits are still moving, and gives
// an accept-to-out_valid latency of WIDTH+1 edges.
module serial_subtractor
    import vlsi_pkg::*;
#(
    parameter int WIDTH = VLSI_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] d_sr;
    logic             borrow_ff;
    logic [CW-1:0]    cnt;
    logic             commit;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;

    logic             accept;
    logic             shifting;
    logic             last_bit;
    logic             cell_d;
    logic             cell_bout;

    assign accept   = (state == ST_IDLE) && bus.in_valid;
    assign shifting = (state == ST_RUN) && !commit;
    assign last_bit = shifting && (cnt == LAST_CNT);

    full_subtractor_bit u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (borrow_ff),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)        state_next = ST_RUN;
            ST_RUN:  if (commit)        state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // Operand/result shift registers, borrow chain and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            d_sr      <= '0;
            borrow_ff <= 1'b0;
            cnt       <= '0;
            commit    <= 1'b0;
        end else if (accept) begin
            a_sr      <= bus.a;
            b_sr      <= bus.b;
            d_sr      <= '0;
            borrow_ff <= 1'b0;
            cnt       <= '0;
            commit    <= 1'b0;
        end else if (shifting) begin
            a_sr      <= a_sr >> 1;
            b_sr      <= b_sr >> 1;
            d_sr      <= {cell_d, d_sr[WIDTH-1:1]};
            borrow_ff <= cell_bout;
            if (last_bit) begin
                commit <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Visible result registers: loaded only on the edge that enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else if ((state == ST_RUN) && commit) begin
            diff_q   <= d_sr;
            borrow_q <= borrow_ff;
        end
    end

    // Handshake and status outputs decoded from the registered state.
    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
        bus.busy      = (state != ST_IDLE);
        bus.diff      = diff_q;
        bus.borrow    = borrow_q;
        bus.state     = state;
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed cases plus randomized operations,
// checked against plain modular arithmetic.
module tb_serial_subtractor;
    import vlsi_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run;
    int tests_failed;

    logic [W:0]   exp_q[$];
    logic [W-1:0] last_diff;
    logic         last_borrow;

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: unsigned subtraction modulo 2^W, borrow when a < b.
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv);
        int unsigned ai;
        int unsigned bi;
        int unsigned d;
        ai = av;
        bi = bv;
        d  = (ai + (1 << W) - bi) % (1 << W);
        return {(ai < bi) ? 1'b1 : 1'b0, d[W-1:0]};
    endfunction

    // One full operation from the negedge before acceptance through the
    // return to IDLE. 'stall' cycles of out_ready=0 after out_valid rises;
    // 'junk' drives in_valid with other operands while the engine is busy.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int stall, input bit junk);
        logic [W:0] exp;
        int         n;
        bus.out_ready = (stall == 0);
        bus.a         = av;
        bus.b         = bv;
        bus.in_valid  = 1'b1;
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        exp_q.push_back(model(av, bv));
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = junk;
        bus.a        = junk ? W'(8'hAA) : W'($urandom);
        bus.b        = junk ? W'(8'h55) : W'($urandom);
        n = 0;
        while (!bus.out_valid && n < 4 * W) begin
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1 || bus.diff !== last_diff)
                check("run_status", {bus.in_ready, bus.busy, bus.diff}, {1'b0, 1'b1, last_diff});
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        check("latency", 32'(n), 32'(W + 1));
        exp = exp_q.pop_front();
        check("diff", 32'(bus.diff), 32'(exp[W-1:0]));
        check("borrow", 32'(bus.borrow), 32'(exp[W]));
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.diff !== exp[W-1:0] || bus.borrow !== exp[W])
                check("stall_hold", {bus.out_valid, bus.borrow, bus.diff}, {1'b1, exp});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_idle", {bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
        check("diff_held", 32'(bus.diff), 32'(exp[W-1:0]));
        last_diff   = exp[W-1:0];
        last_borrow = exp[W];
    endtask

    // Main sequence.
    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        last_diff     = '0;
        last_borrow   = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_status", {bus.in_ready, bus.out_valid, bus.busy, bus.borrow}, 32'b1000);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_state", 32'(bus.state), 32'(ST_IDLE));

        do_op(8'd5, 8'd3, 0, 1'b0);
        do_op(8'd3, 8'd5, 0, 1'b0);
        do_op(8'h00, 8'hFF, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 0, 1'b0);
        do_op(8'h80, 8'h01, 5, 1'b0);
        do_op(8'd10, 8'd4, 0, 1'b1);

        // Asynchronous reset between edges in the middle of RUN.
        bus.out_ready = 1'b1;
        bus.a         = 8'h3C;
        bus.b         = 8'hC3;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_status", {bus.in_ready, bus.out_valid, bus.busy, bus.borrow}, 32'b1000);
        check("arst_diff", 32'(bus.diff), 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        last_diff = '0;
        do_op(8'd9, 8'd9, 0, 1'b0);

        // Randomized operations with random stalls and busy-time noise.
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)));
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        tests_failed++;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_serial_subtractor
